keynsham_bus_master: RTL and testbench
======================================

Name: keynsham_bus_master

Overview:
- Single-outstanding bus initiator for the keynsham peripheral bus.
- Converts a valid/ready command (from the debug controller or a DMA engine) into one bus access.
- Holds the bus until the addressed responder returns bus_ack or bus_error, or until a timeout expires.
- Returns read data and status on a valid/ready response channel.

Parameters:
- timeout_cycles, 256: maximum BUS-state cycles before abandoning an access; legal range 2..2^16-1.
- cnt_width, 16: width of the timeout counter; must hold timeout_cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- req_valid  in  1  command present.
- req_ready  out  1  block can accept a command (high only in IDLE).
- req_addr  in  30  word address.
- req_wr  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_bytesel  in  4  byte enables.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  read data; 0 for writes, errors and timeouts.
- resp_error  out  1  bus_error returned or timeout.
- resp_timeout  out  1  access abandoned by timeout.
- bus_access  out  1  access strobe.
- bus_addr  out  30  access address.
- bus_wr_val  out  32  write data.
- bus_wr_en  out  1  write strobe.
- bus_bytesel  out  4  byte enables.
- bus_ack  in  1  responder completion (registered, ≥1 cycle after access).
- bus_error  in  1  responder error completion.
- bus_data  in  32  read data, valid while bus_ack is high.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; every output 0 except req_ready = 1.
  - Counter and captured command cleared.
  - Reset mid-access abandons the access immediately and produces no response.
- States: IDLE, BUS, RESP (encoding in shared package).
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: capture addr, wr, wdata and bytesel into registers; clear counter; go to BUS.
  - bus_ack and bus_error are ignored in IDLE.
- BUS:
  - bus_access = 1.
  - bus_addr, bus_wr_val and bus_bytesel are driven from the captured registers and held stable.
  - bus_wr_en = captured wr.
  - Counter increments each BUS cycle.
  - bus_error = 1: go to RESP with resp_error = 1, resp_data = 0. Error wins over a simultaneous ack.
  - Else bus_ack = 1: go to RESP; resp_data = bus_data for reads, 0 for writes; resp_error = 0.
  - Else counter == timeout_cycles-1: go to RESP with resp_error = 1, resp_timeout = 1, resp_data = 0.
  - An ack or error arriving in the same cycle as expiry wins over the timeout.
- RESP:
  - resp_valid = 1; response fields held stable.
  - All bus_* outputs are 0.
  - On resp_ready: go to IDLE and clear the resp fields.
  - bus_ack/bus_error ignored; this absorbs the trailing ack a registered responder emits one cycle after bus_access drops.
- Timing:
  - bus_access is asserted the cycle after acceptance.
  - Against a 1-cycle responder: accept at T, access at T+1 and T+2, ack sampled at T+2, resp_valid at T+3.
  - Minimum request-to-request spacing is 4 cycles, which guarantees a stale ack is never seen in BUS.
- Back-pressure: resp_ready may be held low indefinitely; req_ready stays low until the response is taken.
- Bus outputs are registered-state derived; no combinational path from req_* to bus_*.

Decomposition:
- Shared keynsham package defines:
  - state encoding (BM_IDLE, BM_BUS, BM_RESP);
  - BUS_ADDR_W = 30, BUS_DATA_W = 32;
  - default timeout constant.
- No sub-module. The timeout counter is a few lines and stays inline; the response holding registers stay inline.

Test Plan:
- Read from IRQ controller enable register (word offset 1), value 0x0000_0005, 1-cycle responder → bus_access high exactly 2 cycles; resp_valid with resp_data = 0x0000_0005, resp_error = 0, resp_timeout = 0.
- Write 0xDEAD_BEEF to addr 0x100, bytesel 0xF → bus_wr_en = 1, bus_wr_val = 0xDEAD_BEEF held through ack; response resp_data = 0, resp_error = 0.
- Unmapped addr with no responder, timeout_cycles = 8 → bus_access high exactly 8 cycles; resp_error = 1, resp_timeout = 1, resp_data = 0.
- Responder asserts bus_ack and bus_error together with bus_data = 0x1234 → resp_error = 1, resp_timeout = 0, resp_data = 0.
- resp_ready held low 10 cycles, then two back-to-back reads with req_valid held high → second req not accepted until first response taken; trailing ack during RESP ignored; second read returns its own data.
- rst_n pulsed low during BUS of a read → bus_access drops asynchronously; no resp_valid follows; req_ready = 1 after release; next read completes normally.

Source files
------------

// File: rtl/keynsham_bus_master_pkg.sv
// Shared definitions for the keynsham peripheral bus initiator: widths, FSM encoding and
// the default access timeout.
package keynsham_bus_master_pkg;

   localparam int unsigned BUS_ADDR_W      = 30;
   localparam int unsigned BUS_DATA_W      = 32;
   localparam int unsigned BUS_BSEL_W      = BUS_DATA_W / 8;
   localparam int unsigned DEFAULT_TIMEOUT = 256;

   typedef enum logic [1:0] {
      BM_IDLE = 2'd0,
      BM_BUS  = 2'd1,
      BM_RESP = 2'd2
   } bm_state_e;

endpackage

// File: rtl/keynsham_bus_master_if.sv
// Command, response and peripheral-bus signals of the keynsham bus initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface keynsham_bus_master_if;
   import keynsham_bus_master_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [BUS_ADDR_W-1:0] req_addr;
   logic                  req_wr;
   logic [BUS_DATA_W-1:0] req_wdata;
   logic [BUS_BSEL_W-1:0] req_bytesel;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [BUS_DATA_W-1:0] resp_data;
   logic                  resp_error;
   logic                  resp_timeout;

   logic                  bus_access;
   logic [BUS_ADDR_W-1:0] bus_addr;
   logic [BUS_DATA_W-1:0] bus_wr_val;
   logic                  bus_wr_en;
   logic [BUS_BSEL_W-1:0] bus_bytesel;
   logic                  bus_ack;
   logic                  bus_error;
   logic [BUS_DATA_W-1:0] bus_data;

   modport master (
      input  req_valid, req_addr, req_wr, req_wdata, req_bytesel,
      output req_ready,
      output resp_valid, resp_data, resp_error, resp_timeout,
      input  resp_ready,
      output bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
      input  bus_ack, bus_error, bus_data
   );

   modport slave (
      output req_valid, req_addr, req_wr, req_wdata, req_bytesel,
      input  req_ready,
      input  resp_valid, resp_data, resp_error, resp_timeout,
      output resp_ready,
      input  bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
      output bus_ack, bus_error, bus_data
   );

endinterface

// File: rtl/keynsham_bus_master.sv
// Single-outstanding keynsham bus initiator: one command in, one bus access, one response out.
// All outputs come straight from registers, so there is no path from req_* to bus_*.
module keynsham_bus_master
   import keynsham_bus_master_pkg::*;
#(
   parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT,
   parameter int unsigned CntWidth      = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   keynsham_bus_master_if.master  bm_io
);

   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

   bm_state_e             state_q;
   logic                  req_ready_q;
   logic [BUS_ADDR_W-1:0] addr_q;
   logic                  wr_q;
   logic [BUS_DATA_W-1:0] wdata_q;
   logic [BUS_BSEL_W-1:0] bsel_q;
   logic [CntWidth-1:0]   cnt_q;
   logic                  bus_access_q;
   logic                  resp_valid_q;
   logic [BUS_DATA_W-1:0] resp_data_q;
   logic                  resp_error_q;
   logic                  resp_timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= BM_IDLE;
         req_ready_q    <= 1'b1;
         addr_q         <= '0;
         wr_q           <= 1'b0;
         wdata_q        <= '0;
         bsel_q         <= '0;
         cnt_q          <= '0;
         bus_access_q   <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_error_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            BM_IDLE: begin
               if (bm_io.req_valid) begin
                  addr_q       <= bm_io.req_addr;
                  wr_q         <= bm_io.req_wr;
                  wdata_q      <= bm_io.req_wdata;
                  bsel_q       <= bm_io.req_bytesel;
                  cnt_q        <= '0;
                  req_ready_q  <= 1'b0;
                  bus_access_q <= 1'b1;
                  state_q      <= BM_BUS;
               end
            end
            BM_BUS: begin
               cnt_q <= cnt_q + 1'b1;
               // Error beats ack, and either beats a timeout expiring in the same cycle.
               if (bm_io.bus_error) begin
                  bus_access_q <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_error_q <= 1'b1;
                  resp_data_q  <= '0;
                  state_q      <= BM_RESP;
               end else if (bm_io.bus_ack) begin
                  bus_access_q <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_error_q <= 1'b0;
                  resp_data_q  <= wr_q ? '0 : bm_io.bus_data;
                  state_q      <= BM_RESP;
               end else if (cnt_q == CntLast) begin
                  bus_access_q   <= 1'b0;
                  resp_valid_q   <= 1'b1;
                  resp_error_q   <= 1'b1;
                  resp_timeout_q <= 1'b1;
                  resp_data_q    <= '0;
                  state_q        <= BM_RESP;
               end
            end
            BM_RESP: begin
               // A trailing ack from a registered responder lands here and is dropped.
               if (bm_io.resp_ready) begin
                  resp_valid_q   <= 1'b0;
                  resp_data_q    <= '0;
                  resp_error_q   <= 1'b0;
                  resp_timeout_q <= 1'b0;
                  req_ready_q    <= 1'b1;
                  state_q        <= BM_IDLE;
               end
            end
            default: begin
               state_q     <= BM_IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bm_io.req_ready    = req_ready_q;
   assign bm_io.resp_valid   = resp_valid_q;
   assign bm_io.resp_data    = resp_data_q;
   assign bm_io.resp_error   = resp_error_q;
   assign bm_io.resp_timeout = resp_timeout_q;

   assign bm_io.bus_access  = bus_access_q;
   assign bm_io.bus_addr    = bus_access_q ? addr_q  : '0;
   assign bm_io.bus_wr_val  = bus_access_q ? wdata_q : '0;
   assign bm_io.bus_wr_en   = bus_access_q & wr_q;
   assign bm_io.bus_bytesel = bus_access_q ? bsel_q  : '0;

endmodule

// File: tb/tb_keynsham_bus_master.sv
// Self-checking bench for keynsham_bus_master: behavioural responder, scoreboard of expected
// responses pushed on command acceptance and popped on response handshake.
module tb_keynsham_bus_master;
   import keynsham_bus_master_pkg::*;

   localparam int unsigned Timeout = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   keynsham_bus_master_if bm_if ();

   keynsham_bus_master #(
      .TimeoutCycles (Timeout),
      .CntWidth      (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bm_io (bm_if)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        tmo;
      int unsigned len;
   } exp_t;

   typedef enum int {RmAck, RmNone, RmBoth} rmode_e;

   int     n_checks = 0;
   int     n_errors = 0;
   rmode_e rmode    = RmAck;
   exp_t   sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_value(input logic [29:0] a);
      if (a == 30'd1) return 32'h0000_0005;
      return {a, 2'b00} ^ 32'hA5A5_0000;
   endfunction

   // Registered responder: replies one cycle after it sees bus_access, so it also emits
   // a trailing ack in the first response cycle.
   always @(posedge clk) begin
      bm_if.bus_ack   <= 1'b0;
      bm_if.bus_error <= 1'b0;
      bm_if.bus_data  <= 32'h0;
      if (bm_if.bus_access) begin
         case (rmode)
            RmAck: begin
               bm_if.bus_ack  <= 1'b1;
               bm_if.bus_data <= rd_value(bm_if.bus_addr);
            end
            RmBoth: begin
               bm_if.bus_ack   <= 1'b1;
               bm_if.bus_error <= 1'b1;
               bm_if.bus_data  <= 32'h0000_1234;
            end
            default: ;
         endcase
      end
   end

   int unsigned acc_len = 0;
   logic [29:0] cur_addr;
   logic        cur_wr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_bsel;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bm_if.req_valid && bm_if.req_ready) begin
            exp_t e;
            cur_addr  = bm_if.req_addr;
            cur_wr    = bm_if.req_wr;
            cur_wdata = bm_if.req_wdata;
            cur_bsel  = bm_if.req_bytesel;
            case (rmode)
               RmAck:   e = '{cur_wr ? 32'h0 : rd_value(cur_addr), 1'b0, 1'b0, 2};
               RmNone:  e = '{32'h0, 1'b1, 1'b1, Timeout};
               default: e = '{32'h0, 1'b1, 1'b0, 2};
            endcase
            sb_q.push_back(e);
         end
         if (bm_if.bus_access) begin
            acc_len++;
            check_eq("bus_addr", {2'b00, bm_if.bus_addr}, {2'b00, cur_addr});
            check_eq("bus_wr_val", bm_if.bus_wr_val, cur_wdata);
            check_eq("bus_ctl", {27'h0, bm_if.bus_bytesel, bm_if.bus_wr_en}, {27'h0, cur_bsel, cur_wr});
         end
         if (bm_if.resp_valid) begin
            check_eq("bus_quiet_in_resp",
                     {31'h0, bm_if.bus_access | bm_if.bus_wr_en | (|bm_if.bus_addr) |
                             (|bm_if.bus_wr_val) | (|bm_if.bus_bytesel)}, 32'h0);
         end
         if (bm_if.resp_valid && bm_if.resp_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("resp_unexpected", 32'h1, 32'h0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_eq("resp_data", bm_if.resp_data, e.data);
               check_eq("resp_error", {31'h0, bm_if.resp_error}, {31'h0, e.err});
               check_eq("resp_timeout", {31'h0, bm_if.resp_timeout}, {31'h0, e.tmo});
               check_eq("access_len", acc_len, e.len);
            end
            acc_len = 0;
         end
      end
   end

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bm_if.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("req_accept_bound", 32'h0, 32'h1);
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [29:0] a, input logic wr, input logic [31:0] wd,
                            input logic [3:0] bs);
      @(posedge clk);
      #1;
      bm_if.req_valid   = 1'b1;
      bm_if.req_addr    = a;
      bm_if.req_wr      = wr;
      bm_if.req_wdata   = wd;
      bm_if.req_bytesel = bs;
      wait_accept();
      bm_if.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("resp_bound", 32'h0, 32'h1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      bit ok;
      bm_if.req_valid   = 1'b0;
      bm_if.req_addr    = '0;
      bm_if.req_wr      = 1'b0;
      bm_if.req_wdata   = '0;
      bm_if.req_bytesel = '0;
      bm_if.resp_ready  = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_req_ready", {31'h0, bm_if.req_ready}, 32'h1);
      check_eq("rst_resp_valid", {31'h0, bm_if.resp_valid}, 32'h0);
      check_eq("rst_bus_access", {31'h0, bm_if.bus_access}, 32'h0);
      check_eq("rst_resp_data", bm_if.resp_data, 32'h0);
      rst_n = 1'b1;

      // Read of the IRQ enable register, then a full-word write.
      rmode = RmAck;
      drive_req(30'd1, 1'b0, 32'h0, 4'hF);
      wait_drain();
      drive_req(30'h100, 1'b1, 32'hDEAD_BEEF, 4'hF);
      wait_drain();

      rmode = RmNone;
      drive_req(30'h3FFF_0000, 1'b0, 32'h0, 4'hF);
      wait_drain();

      rmode = RmBoth;
      drive_req(30'h40, 1'b0, 32'h0, 4'h3);
      wait_drain();

      // Back-pressure with a second read already waiting on req_valid.
      rmode = RmAck;
      bm_if.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      bm_if.req_valid   = 1'b1;
      bm_if.req_addr    = 30'h11;
      bm_if.req_wr      = 1'b0;
      bm_if.req_wdata   = 32'h0;
      bm_if.req_bytesel = 4'hF;
      wait_accept();
      bm_if.req_addr    = 30'h22;
      bm_if.req_bytesel = 4'h5;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bm_if.resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("bp_resp_seen", {31'h0, ok}, 32'h1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("bp_req_ready", {31'h0, bm_if.req_ready}, 32'h0);
         check_eq("bp_resp_hold", {bm_if.resp_data[30:0], bm_if.resp_valid},
                  {rd_value(30'h11) << 1 | 32'h1});
      end
      @(posedge clk);
      #1;
      bm_if.resp_ready = 1'b1;
      wait_accept();
      bm_if.req_valid = 1'b0;
      wait_drain();

      // Reset in the middle of an access that would otherwise run to timeout.
      rmode = RmNone;
      drive_req(30'h33, 1'b0, 32'h0, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_bus_access", {31'h0, bm_if.bus_access}, 32'h0);
      check_eq("rst_mid_req_ready", {31'h0, bm_if.req_ready}, 32'h1);
      check_eq("rst_mid_resp_valid", {31'h0, bm_if.resp_valid}, 32'h0);
      sb_q.delete();
      acc_len = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rmode = RmAck;
      seen  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= bm_if.resp_valid;
      end
      check_eq("no_resp_after_rst", {31'h0, seen}, 32'h0);
      check_eq("req_ready_after_rst", {31'h0, bm_if.req_ready}, 32'h1);
      drive_req(30'd7, 1'b0, 32'h0, 4'hF);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
